// File: rtl/regfile_writeback_if.sv
// Signal bundle between regfile_writeback and its neighbours (ALU/load path,
// mul/div unit, decode hazard check, register-file write port).
// Ports: ALU result, mul/div valid/ready push, issue marking, busy lookups,
// registered write-port outputs; bypass lookups when WB_BYPASS_EN is defined.
// Modports: slave = writeback block, master = surrounding pipeline.

interface regfile_writeback_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // ALU/load producer, always accepted
   logic              aluValid;
   logic [ADDR_W-1:0] aluAddr;
   logic [DATA_W-1:0] aluData;

   // mul/div producer, valid/ready handshake
   logic              mdValid;
   logic              mdReady;
   logic [ADDR_W-1:0] mdAddr;
   logic [DATA_W-1:0] mdData;

   // mul/div issue marks the destination pending
   logic              issueValid;
   logic [ADDR_W-1:0] issueAddr;

   // decode hazard lookups
   logic [ADDR_W-1:0] busyAddr1;
   logic [ADDR_W-1:0] busyAddr2;
   logic              busy1;
   logic              busy2;

   // register-file write port
   logic [DATA_W-1:0] dataWrite;
   logic [ADDR_W-1:0] addrWriteReg;
   logic              regWrite;

`ifdef WB_BYPASS_EN
   logic [ADDR_W-1:0] fwdAddr1;
   logic [ADDR_W-1:0] fwdAddr2;
   logic [DATA_W-1:0] fwdData1;
   logic [DATA_W-1:0] fwdData2;
   logic              fwdHit1;
   logic              fwdHit2;
`endif

   modport slave (
      input  aluValid, aluAddr, aluData,
      input  mdValid, mdAddr, mdData,
      output mdReady,
      input  issueValid, issueAddr,
      input  busyAddr1, busyAddr2,
      output busy1, busy2,
      output dataWrite, addrWriteReg, regWrite
`ifdef WB_BYPASS_EN
      ,
      input  fwdAddr1, fwdAddr2,
      output fwdData1, fwdData2, fwdHit1, fwdHit2
`endif
   );

   modport master (
      output aluValid, aluAddr, aluData,
      output mdValid, mdAddr, mdData,
      input  mdReady,
      output issueValid, issueAddr,
      output busyAddr1, busyAddr2,
      input  busy1, busy2,
      input  dataWrite, addrWriteReg, regWrite
`ifdef WB_BYPASS_EN
      ,
      output fwdAddr1, fwdAddr2,
      input  fwdData1, fwdData2, fwdHit1, fwdHit2
`endif
   );

endinterface

// File: rtl/regfile_writeback.sv
// Purpose: register-file write-side controller merging the single-cycle ALU/load
//          path and a FIFO-buffered mul/div path onto one registered write port,
//          plus a pending-register scoreboard for decode hazard stalls.
// Latency: ALU result -> write 1 cycle; mul/div push -> write 2 cycles (no ALU conflict).
// Backpressure: ALU never stalls; mdReady = !full from registered state only.
// Ports: clk, rst (sync active-high), wb (regfile_writeback_if.slave).
// Optional: define WB_BYPASS_EN for combinational forwarding of the write port.

// Generic single-clock FIFO. Occupancy count disambiguates full/empty;
// push_rdy depends on stored state only, so a same-cycle pop never raises it.
module wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_req,
   output logic             pop_vld,
   output logic [WIDTH-1:0] pop_dat
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push, pop;

   assign push_rdy = (count_q != FULL_CNT);
   assign pop_vld  = (count_q != '0);
   assign pop_dat  = mem_q[rd_ptr_q];
   assign push     = push_vld && push_rdy;
   assign pop      = pop_req && pop_vld;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // power-of-two depth: pointers wrap by natural overflow
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: an entry is only read while count says it is live
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_dat;
   end
endmodule

module regfile_writeback #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   regfile_writeback_if.slave wb
);
   localparam int NREG = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dat;
   } md_ent_t;

   // ---------------- mul/div result buffer ----------------
   md_ent_t push_ent;
   md_ent_t head_ent;
   logic    fifo_vld;
   logic    fifo_pop;
   logic    md_rdy;

   assign push_ent = '{addr: wb.mdAddr, dat: wb.mdData};

   wb_fifo #(
      .WIDTH ($bits(md_ent_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_md_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (wb.mdValid),
      .push_rdy (md_rdy),
      .push_dat (push_ent),
      .pop_req  (fifo_pop),
      .pop_vld  (fifo_vld),
      .pop_dat  (head_ent)
   );

   assign wb.mdReady = md_rdy;

   // ---------------- write-port arbitration ----------------
   logic              sel_vld;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_dat;

   logic              wr_vld_q,   wr_vld_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_W-1:0] wr_dat_q,   wr_dat_d;
   // remembers which mul/div write is on the port so its pending bit can be
   // released at the edge that ends the write cycle
   logic              clr_vld_q,  clr_vld_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   always_comb begin
      sel_vld  = 1'b0;
      sel_addr = '0;
      sel_dat  = '0;
      fifo_pop = 1'b0;
      if (wb.aluValid) begin
         sel_vld  = 1'b1;
         sel_addr = wb.aluAddr;
         sel_dat  = wb.aluData;
      end else if (fifo_vld) begin
         fifo_pop = 1'b1;
         sel_vld  = 1'b1;
         sel_addr = head_ent.addr;
         sel_dat  = head_ent.dat;
      end

      // r0 is hardwired: suppress the write entirely, but the pop above still
      // consumes the entry
      wr_vld_d   = sel_vld && (sel_addr != '0);
      wr_addr_d  = wr_vld_d ? sel_addr : '0;
      wr_dat_d   = wr_vld_d ? sel_dat  : '0;

      clr_vld_d  = fifo_pop;
      clr_addr_d = fifo_pop ? head_ent.addr : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_vld_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_dat_q   <= '0;
         clr_vld_q  <= 1'b0;
         clr_addr_q <= '0;
      end else begin
         wr_vld_q   <= wr_vld_d;
         wr_addr_q  <= wr_addr_d;
         wr_dat_q   <= wr_dat_d;
         clr_vld_q  <= clr_vld_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign wb.regWrite     = wr_vld_q;
   assign wb.addrWriteReg = wr_addr_q;
   assign wb.dataWrite    = wr_dat_q;

   // ---------------- pending-register scoreboard ----------------
   logic [NREG-1:0] pend_q, pend_d;

   always_comb begin
      pend_d = pend_q;
      // clear first so a same-edge re-issue of the register keeps it pending
      if (clr_vld_q) pend_d[clr_addr_q] = 1'b0;
      if (wb.issueValid && (wb.issueAddr != '0)) pend_d[wb.issueAddr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   // busy stays high through the write cycle, so a regfile read in the first
   // non-busy cycle already sees the new value
   assign wb.busy1 = pend_q[wb.busyAddr1];
   assign wb.busy2 = pend_q[wb.busyAddr2];

`ifdef WB_BYPASS_EN
   // ---------------- write-port forwarding ----------------
   logic fwd_hit1, fwd_hit2;

   assign fwd_hit1    = wr_vld_q && (wr_addr_q == wb.fwdAddr1) && (wb.fwdAddr1 != '0);
   assign fwd_hit2    = wr_vld_q && (wr_addr_q == wb.fwdAddr2) && (wb.fwdAddr2 != '0);
   assign wb.fwdHit1  = fwd_hit1;
   assign wb.fwdHit2  = fwd_hit2;
   assign wb.fwdData1 = fwd_hit1 ? wr_dat_q : '0;
   assign wb.fwdData2 = fwd_hit2 ? wr_dat_q : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the writeback rules.

module tb_regfile_writeback;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int FIFO_DEPTH = 4;
   localparam int NREG       = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb_if ();

   regfile_writeback #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb_if)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t              mq[$];          // buffered mul/div results, oldest first
   bit                pend[NREG];     // registers awaiting a mul/div write
   bit                ret_vld;        // a mul/div write is on the port this cycle
   int                ret_addr;
   bit                exp_we;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_dat;
   bit                model_ok = 1'b0;
   logic [DATA_W-1:0] rf[NREG];       // register file as seen through the write port

   ent_t m_sel;
   ent_t m_new;
   bit   m_have;
   bit   m_can_push;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         foreach (pend[i]) pend[i] = 1'b0;
         ret_vld  = 1'b0;
         ret_addr = 0;
         exp_we   = 1'b0;
         exp_addr = '0;
         exp_dat  = '0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         m_can_push = (mq.size() < FIFO_DEPTH);
         if (ret_vld) pend[ret_addr] = 1'b0;
         if (wb_if.issueValid && wb_if.issueAddr != 0) pend[wb_if.issueAddr] = 1'b1;
         ret_vld = 1'b0;
         m_have  = 1'b0;
         m_sel.a = '0;
         m_sel.d = '0;
         if (wb_if.aluValid) begin
            m_sel.a = wb_if.aluAddr;
            m_sel.d = wb_if.aluData;
            m_have  = 1'b1;
         end else if (mq.size() > 0) begin
            m_sel    = mq.pop_front();
            m_have   = 1'b1;
            ret_vld  = 1'b1;
            ret_addr = int'(m_sel.a);
         end
         if (wb_if.mdValid && m_can_push) begin
            m_new.a = wb_if.mdAddr;
            m_new.d = wb_if.mdData;
            mq.push_back(m_new);
         end
         exp_we   = m_have && (m_sel.a != 0);
         exp_addr = exp_we ? m_sel.a : '0;
         exp_dat  = exp_we ? m_sel.d : '0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_ok) begin
         check("regWrite",     32'(wb_if.regWrite),     32'(exp_we));
         check("addrWriteReg", 32'(wb_if.addrWriteReg), 32'(exp_addr));
         check("dataWrite",    wb_if.dataWrite,         exp_dat);
         check("mdReady",      32'(wb_if.mdReady),      32'(mq.size() < FIFO_DEPTH));
         check("busy1",        32'(wb_if.busy1),        32'(pend[wb_if.busyAddr1]));
         check("busy2",        32'(wb_if.busy2),        32'(pend[wb_if.busyAddr2]));
`ifdef WB_BYPASS_EN
         check("fwdHit1",  32'(wb_if.fwdHit1),
               32'(exp_we && exp_addr == wb_if.fwdAddr1 && wb_if.fwdAddr1 != 0));
         check("fwdData1", wb_if.fwdData1,
               (exp_we && exp_addr == wb_if.fwdAddr1 && wb_if.fwdAddr1 != 0) ? exp_dat : 32'h0);
         check("fwdHit2",  32'(wb_if.fwdHit2),
               32'(exp_we && exp_addr == wb_if.fwdAddr2 && wb_if.fwdAddr2 != 0));
         check("fwdData2", wb_if.fwdData2,
               (exp_we && exp_addr == wb_if.fwdAddr2 && wb_if.fwdAddr2 != 0) ? exp_dat : 32'h0);
`endif
         if (wb_if.regWrite) rf[wb_if.addrWriteReg] = wb_if.dataWrite;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      wb_if.aluValid   = 1'b0;
      wb_if.aluAddr    = '0;
      wb_if.aluData    = '0;
      wb_if.mdValid    = 1'b0;
      wb_if.mdAddr     = '0;
      wb_if.mdData     = '0;
      wb_if.issueValid = 1'b0;
      wb_if.issueAddr  = '0;
      wb_if.busyAddr1  = '0;
      wb_if.busyAddr2  = '0;
`ifdef WB_BYPASS_EN
      wb_if.fwdAddr1   = '0;
      wb_if.fwdAddr2   = '0;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wb_if.busyAddr1 = 5'd4;

      // reset state
      @(negedge clk);
      check("rst_regWrite", 32'(wb_if.regWrite), 32'd0);
      check("rst_mdReady",  32'(wb_if.mdReady),  32'd1);
      check("rst_busy1",    32'(wb_if.busy1),    32'd0);

      // ALU only
      idle();
      wb_if.aluValid = 1'b1; wb_if.aluAddr = 5'd5; wb_if.aluData = 32'h1234;
      step();
      idle();
      @(negedge clk);
      check("alu_we",   32'(wb_if.regWrite),     32'd1);
      check("alu_addr", 32'(wb_if.addrWriteReg), 32'd5);
      check("alu_data", wb_if.dataWrite,         32'h1234);
      step();
      @(negedge clk);
      check("alu_we_off", 32'(wb_if.regWrite), 32'd0);

      // ALU and mul/div in the same cycle
      wb_if.aluValid = 1'b1; wb_if.aluAddr = 5'd3; wb_if.aluData = 32'hA;
      wb_if.mdValid  = 1'b1; wb_if.mdAddr  = 5'd7; wb_if.mdData  = 32'hB;
      step();
      idle();
      @(negedge clk);
      check("cfl_addr1", 32'(wb_if.addrWriteReg), 32'd3);
      check("cfl_data1", wb_if.dataWrite,         32'hA);
      step();
      @(negedge clk);
      check("cfl_we2",   32'(wb_if.regWrite),     32'd1);
      check("cfl_addr2", 32'(wb_if.addrWriteReg), 32'd7);
      check("cfl_data2", wb_if.dataWrite,         32'hB);
      repeat (2) step();

      // FIFO fill while the ALU holds the port
      for (int k = 1; k <= 6; k++) begin
         wb_if.aluValid = 1'b1;
         wb_if.aluAddr  = 5'd1;
         wb_if.aluData  = 32'(100 + k);
         wb_if.mdValid  = (k <= 5);
         wb_if.mdAddr   = ADDR_W'(10 + k);
         wb_if.mdData   = 32'(k);
         step();
         if (k == 4) begin
            @(negedge clk);
            check("full_mdReady", 32'(wb_if.mdReady), 32'd0);
         end
      end
      idle();
      for (int j = 1; j <= 4; j++) begin
         step();
         @(negedge clk);
         check("drain_we",   32'(wb_if.regWrite), 32'd1);
         check("drain_data", wb_if.dataWrite,     32'(j));
      end
      repeat (3) step();

      // scoreboard round trip on r9
      wb_if.issueValid = 1'b1; wb_if.issueAddr = 5'd9; wb_if.busyAddr1 = 5'd9;
      step();
      wb_if.issueValid = 1'b0;
      @(negedge clk);
      check("sb_busy_set", 32'(wb_if.busy1), 32'd1);
      wb_if.mdValid = 1'b1; wb_if.mdAddr = 5'd9; wb_if.mdData = 32'h99;
      step();
      wb_if.mdValid = 1'b0;
      step();
      @(negedge clk);
      check("sb_we",        32'(wb_if.regWrite),     32'd1);
      check("sb_addr",      32'(wb_if.addrWriteReg), 32'd9);
      check("sb_busy_hold", 32'(wb_if.busy1),        32'd1);
      step();
      @(negedge clk);
      check("sb_busy_clr", 32'(wb_if.busy1), 32'd0);
      check("sb_rf_r9",    rf[9],            32'h99);
      repeat (2) step();

      // register 0 is never written nor marked busy
      idle();
      wb_if.issueValid = 1'b1; wb_if.issueAddr = 5'd0;
      step();
      wb_if.issueValid = 1'b0;
      wb_if.mdValid = 1'b1; wb_if.mdAddr = 5'd0; wb_if.mdData = 32'hDEAD;
      @(negedge clk);
      check("r0_busy_issue", 32'(wb_if.busy1), 32'd0);
      step();
      wb_if.mdValid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("r0_we",   32'(wb_if.regWrite), 32'd0);
         check("r0_busy", 32'(wb_if.busy1),    32'd0);
         step();
      end

      // reset with buffered entries and a pending register
      idle();
      wb_if.aluValid = 1'b1; wb_if.aluAddr = 5'd1; wb_if.aluData = 32'h11;
      wb_if.issueValid = 1'b1; wb_if.issueAddr = 5'd4;
      wb_if.mdValid = 1'b1; wb_if.mdAddr = 5'd4; wb_if.mdData = 32'h44;
      step();
      wb_if.issueValid = 1'b0;
      wb_if.mdAddr = 5'd12; wb_if.mdData = 32'h55;
      step();
      wb_if.mdValid = 1'b0;
      wb_if.busyAddr1 = 5'd4;
      @(negedge clk);
      check("mid_busy_before", 32'(wb_if.busy1), 32'd1);
      rst = 1'b1;
      wb_if.aluValid = 1'b0;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mid_we",      32'(wb_if.regWrite), 32'd0);
      check("mid_mdReady", 32'(wb_if.mdReady),  32'd1);
      check("mid_busy",    32'(wb_if.busy1),    32'd0);
      for (int j = 0; j < 4; j++) begin
         step();
         @(negedge clk);
         check("mid_no_stale", 32'(wb_if.regWrite), 32'd0);
      end

`ifdef WB_BYPASS_EN
      // forwarding of the write port
      idle();
      wb_if.aluValid = 1'b1; wb_if.aluAddr = 5'd6; wb_if.aluData = 32'h66;
      wb_if.fwdAddr1 = 5'd6; wb_if.fwdAddr2 = 5'd7;
      step();
      wb_if.aluValid = 1'b0;
      @(negedge clk);
      check("byp_hit1",  32'(wb_if.fwdHit1), 32'd1);
      check("byp_data1", wb_if.fwdData1,     32'h66);
      check("byp_hit2",  32'(wb_if.fwdHit2), 32'd0);
      step();
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         wb_if.aluValid   = ($urandom_range(0, 99) < 35);
         wb_if.aluAddr    = ADDR_W'($urandom_range(0, 31));
         wb_if.aluData    = $urandom();
         wb_if.mdValid    = ($urandom_range(0, 99) < 50);
         wb_if.mdAddr     = ADDR_W'($urandom_range(0, 31));
         wb_if.mdData     = $urandom();
         wb_if.issueValid = ($urandom_range(0, 99) < 25);
         wb_if.issueAddr  = ADDR_W'($urandom_range(0, 31));
         wb_if.busyAddr1  = ADDR_W'($urandom_range(0, 31));
         wb_if.busyAddr2  = ADDR_W'($urandom_range(0, 31));
`ifdef WB_BYPASS_EN
         wb_if.fwdAddr1   = ADDR_W'($urandom_range(0, 31));
         wb_if.fwdAddr2   = ADDR_W'($urandom_range(0, 31));
`endif
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      idle();
      repeat (8) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
